// File: rtl/muldiv_hilo_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer and sole writer of the HI/LO register pair.
// Optional macro MULDIV_DIVZERO_FAST_EN: divide by zero completes in one cycle.
module muldiv_hilo_ctrl #(
  parameter int unsigned MUL_LAT  = 2,
  parameter int unsigned DIV_ITER = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] opa_i,
  input  logic [31:0] opb_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic        busy_o,
  output logic [1:0]  hilo_we_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        done_o
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q;
  logic        mul_q;
  logic [63:0] prod_q [MUL_LAT];
  logic [63:0] rq_q;
  logic [31:0] dvs_q;
  logic        sgnq_q, sgnr_q;
  logic [31:0] res_hi_q, res_lo_q;

  logic        accept, op_mul, op_div, op_signed;
  logic [63:0] ma, mb, prod_d;
  logic [31:0] abs_a, abs_b;
  logic [32:0] top;
  logic        ge;
  logic [31:0] diff;
  logic [63:0] step;
  logic [31:0] q_fix, r_fix;
  logic        mul_last, div_last;
`ifdef MULDIV_DIVZERO_FAST_EN
  logic        div_zero;
`endif

  always_comb begin
    op_mul    = (op_i == 3'b000) || (op_i == 3'b001);
    op_div    = (op_i == 3'b010) || (op_i == 3'b011);
    op_signed = ~op_i[0];
    accept    = rst && start_i && !flush_i && (state_q == S_IDLE);
    ma        = {{32{op_signed & opa_i[31]}}, opa_i};
    mb        = {{32{op_signed & opb_i[31]}}, opb_i};
    prod_d    = ma * mb;
    abs_a     = (op_signed && opa_i[31]) ? (32'd0 - opa_i) : opa_i;
    abs_b     = (op_signed && opb_i[31]) ? (32'd0 - opb_i) : opb_i;
`ifdef MULDIV_DIVZERO_FAST_EN
    div_zero  = (opb_i == '0);
`endif
    // Restoring step: the 33-bit partial remainder includes the bit about to shift out.
    top      = rq_q[63:31];
    ge       = top >= {1'b0, dvs_q};
    diff     = top[31:0] - dvs_q;
    step     = ge ? {diff, rq_q[30:0], 1'b1} : {rq_q[62:0], 1'b0};
    q_fix    = sgnq_q ? (32'd0 - step[31:0])  : step[31:0];
    r_fix    = sgnr_q ? (32'd0 - step[63:32]) : step[63:32];
    mul_last = (cnt_q == 5'(MUL_LAT - 2));
    div_last = (cnt_q == 5'(DIV_ITER - 1));
  end

  always_comb begin
    state_d   = state_q;
    stall_o   = 1'b0;
    busy_o    = (state_q != S_IDLE);
    hilo_we_o = '0;
    hi_o      = '0;
    lo_o      = '0;
    done_o    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (op_mul) begin
            stall_o = 1'b1;
            state_d = (MUL_LAT == 1) ? S_DONE : S_MUL;
          end else if (op_div) begin
            stall_o = 1'b1;
            state_d = S_DIV;
`ifdef MULDIV_DIVZERO_FAST_EN
            if (div_zero) state_d = S_DONE;
`endif
          end else if (op_i == 3'b100) begin
            hilo_we_o = 2'b10;
            hi_o      = opa_i;
          end else if (op_i == 3'b101) begin
            hilo_we_o = 2'b01;
            lo_o      = opa_i;
          end
        end
      end
      S_MUL: begin
        stall_o = 1'b1;
        if (flush_i)       state_d = S_IDLE;
        else if (mul_last) state_d = S_DONE;
      end
      S_DIV: begin
        stall_o = 1'b1;
        if (flush_i)       state_d = S_IDLE;
        else if (div_last) state_d = S_DONE;
      end
      S_DONE: begin
        hilo_we_o = 2'b11;
        done_o    = 1'b1;
        hi_o      = mul_q ? prod_q[MUL_LAT-1][63:32] : res_hi_q;
        lo_o      = mul_q ? prod_q[MUL_LAT-1][31:0]  : res_lo_q;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      mul_q    <= 1'b0;
      rq_q     <= '0;
      dvs_q    <= '0;
      sgnq_q   <= 1'b0;
      sgnr_q   <= 1'b0;
      res_hi_q <= '0;
      res_lo_q <= '0;
      for (int unsigned i = 0; i < MUL_LAT; i++) prod_q[i] <= '0;
    end else begin
      state_q <= state_d;
      for (int unsigned i = 1; i < MUL_LAT; i++) prod_q[i] <= prod_q[i-1];
      if (accept && op_mul) begin
        prod_q[0] <= prod_d;
        mul_q     <= 1'b1;
        cnt_q     <= '0;
      end
      if (accept && op_div) begin
        rq_q   <= {32'd0, abs_a};
        dvs_q  <= abs_b;
        sgnq_q <= op_signed & (opa_i[31] ^ opb_i[31]);
        sgnr_q <= op_signed & opa_i[31];
        cnt_q  <= '0;
        mul_q  <= 1'b0;
`ifdef MULDIV_DIVZERO_FAST_EN
        if (div_zero) begin
          res_hi_q <= opa_i;
          res_lo_q <= '1;
        end
`endif
      end
      if (state_q == S_MUL) cnt_q <= cnt_q + 5'd1;
      if (state_q == S_DIV) begin
        rq_q  <= step;
        cnt_q <= cnt_q + 5'd1;
        if (div_last) begin
          res_hi_q <= r_fix;
          res_lo_q <= q_fix;
        end
      end
    end
  end

endmodule

// File: doc/muldiv_hilo_ctrl.md
Name: muldiv_hilo_ctrl

Overview:
Multi-cycle multiply/divide sequencer that owns every write into the HI/LO register pair. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the EX stage and holds the pipeline with a stall while an operation runs. It then issues a single write strobe (write-enable, HI data, LO data) to the HI/LO register file. The block sits between the EX stage and the HI/LO registers and replaces direct EX-to-HI/LO writes.

Parameters:
MUL_LAT, 2, cycles from accept to result for MULT/MULTU (legal range 1..8)
DIV_ITER, 32, restoring-division iterations; fixed at 32 for 32-bit operands

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low (0 = reset asserted)
start_i  in  1  operation request from EX
op_i  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others = no-op
opa_i  in  32  rs operand / dividend / MTHI-MTLO data
opb_i  in  32  rt operand / divisor
flush_i  in  1  abort the in-flight operation (exception/branch flush)
stall_o  out  1  pipeline hold request
busy_o  out  1  FSM not in IDLE
hilo_we_o  out  2  [1]=HI write, [0]=LO write, to HI/LO register
hi_o  out  32  HI write data
lo_o  out  32  LO write data
done_o  out  1  one-cycle pulse on mul/div result write

Behaviour:
- Reset (rst=0, asynchronous): FSM=IDLE; all outputs 0; internal operand, count and accumulator registers cleared.
- States: IDLE, MUL, DIV, DONE.
- IDLE, start_i=1, op=MTHI: combinational hilo_we_o=10 with hi_o=opa_i in the same cycle; no stall; stay IDLE.
- IDLE, start_i=1, op=MTLO: combinational hilo_we_o=01 with lo_o=opa_i in the same cycle; no stall; stay IDLE.
- IDLE, start_i=1, op=MULT/MULTU:
  - stall_o=1 combinationally in the accept cycle T.
  - Latch operands; signed for MULT, zero-extended for MULTU. Compute a 64-bit product through a MUL_LAT-deep pipeline.
  - Go to MUL; stay for MUL_LAT-1 cycles, then go to DONE.
- IDLE, start_i=1, op=DIV/DIVU:
  - stall_o=1 in the accept cycle T.
  - Latch |a| and |b|; DIV uses the sign bits, DIVU treats operands as unsigned. Also latch sign_q = a[31]^b[31] and sign_r = a[31] (DIV only).
  - Clear the counter; go to DIV.
- DIV: one restoring step per cycle over a 64-bit remainder/quotient shift register. After DIV_ITER steps (cycles T+1..T+32), apply the sign fixup: negate the quotient if sign_q; negate the remainder if sign_r. Then go to DONE.
- DONE, one cycle:
  - hilo_we_o=11, done_o=1, stall_o=0. Registered values: HI=remainder or product[63:32], LO=quotient or product[31:0].
  - Next state is IDLE.
  - Result write cycle: MUL = T+MUL_LAT; DIV = T+33.
- stall_o is 1 in the accept cycle and in every MUL/DIV cycle; it is 0 in IDLE without a mul/div request and in DONE.
- hilo_we_o is 00 in all other cycles; hi_o and lo_o are 0 when hilo_we_o=00.
- start_i while not IDLE: ignored, no state effect. The pipeline is stalled, so this is a protocol error; the bench flags it.
- op_i 110 or 111: no-op, no stall.
- flush_i=1 in MUL or DIV: return to IDLE on the next edge with no write.
- flush_i=1 in DONE: ignored; the write commits.
- flush_i=1 with start_i=1 in IDLE: the request is dropped; no write, no stall.
- Divide by zero (without macro): run the full 32 iterations. The unsigned core yields q=FFFFFFFF, r=|a|, then the normal sign fixup applies with b=0 treated as positive.
- Overflow case DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.

Optional Feature:
MULDIV_DIVZERO_FAST_EN
- Defined: DIV/DIVU with opb_i=0 skips the DIV state and goes from IDLE straight to DONE. The write lands at T+1 with HI=opa_i and LO=FFFFFFFF for both signednesses.
- Undefined: divide by zero behaves as described in Behaviour (T+33, sign-fixed results).

Test Plan:
- MULTU a=FFFFFFFF, b=2 at T, MUL_LAT=2 -> hilo_we_o=11 at T+2, HI=00000001, LO=FFFFFFFE; stall_o=1 at T and T+1 only.
- DIV a=-7 (FFFFFFF9), b=2 at T -> write at T+33, LO=FFFFFFFD (-3), HI=FFFFFFFF (-1); busy_o=1 from T+1 through T+33.
- MTHI opa=12345678, then MTLO opa=9ABCDEF0 on consecutive cycles -> hilo_we_o=10 then 01 in the same cycles with matching data; stall_o stays 0.
- DIVU a=100, b=7, flush_i=1 at T+10 -> IDLE at T+11; hilo_we_o never nonzero; next MULT 3*-4 gives HI=FFFFFFFF, LO=FFFFFFF4.
- DIV a=-7, b=0 -> without macro at T+33: HI=FFFFFFF9, LO=00000001. With MULDIV_DIVZERO_FAST_EN at T+1: HI=FFFFFFF9, LO=FFFFFFFF.
- rst driven low during DIV iteration 15 -> outputs go to 0 immediately; after release, FSM is IDLE and a fresh MULT 5*6 gives LO=0000001E, HI=0.
